led_cmd_sequencer: RTL and testbench
====================================

# led_cmd_sequencer

Command-driven controller for the board's three active-low LEDs (red, green, blue). It consumes command bytes from the UART receive path over a valid/ready handshake and keeps a per-channel enable. It also generates a programmable blink and an R→G→B sweep sequence. It replaces per-colour toggle FSMs as the single owner of the LED pins.

## Interface
- TICK_DIV, 50000: Clock cycles per tick (1 kHz at 50 MHz); ≥2.
- STEP_TICKS, 100: Ticks per period unit; ≥1.
- Clock  in  1  System clock; all logic on rising edge.
- Reset  in  1  Asynchronous, active-high reset.
- Cmd  in  8  Command byte (ASCII).
- CmdValid  in  1  Cmd is valid this cycle.
- CmdReady  out  1  Block can accept a byte this cycle.
- R_LED  out  1  Red LED, active low (0 = lit).
- G_LED  out  1  Green LED, active low.
- B_LED  out  1  Blue LED, active low.
- Sweeping  out  1  High while in SWEEP mode.

## Operation
- Accept occurs when CmdValid && CmdReady at a rising edge. The block drives CmdReady low for exactly the one cycle after each accept, then high again. It never holds CmdReady low longer than that.
- Registers:
  - en[2:0] (R,G,B): reset 3'b111.
  - period P[3:0]: reset 0, where 0 means blink off.
  - mode ∈ {STATIC, SWEEP}: reset STATIC.
  - parser ∈ {P_IDLE, P_ARG}: reset P_IDLE.
  - phase: reset 1.
  - sweep index idx ∈ {R,G,B}: reset R.
- Parser in P_IDLE, by accepted byte:
  - 'R'(82)/'r'(114) set/clear en[R].
  - 'G'(71)/'g'(103) set/clear en[G].
  - 'B'(66)/'b'(98) set/clear en[B].
  - 'F'(70) moves the parser to P_ARG.
  - 'S'(83): mode←SWEEP, idx←R, step counter cleared.
  - 'X'(88): mode←STATIC.
  - Any other byte is consumed and ignored.
- Parser in P_ARG:
  - A digit '0'..'9'(48..57) sets P←digit, clears the step counter, sets phase←1, and returns to P_IDLE.
  - Any other byte is consumed, P is unchanged, and the parser returns to P_IDLE. The byte is not reinterpreted.
  - mode is never affected by the parser state.
- Half-period H:
  - H = P·STEP_TICKS ticks when P≠0.
  - H = STEP_TICKS when P=0; this value is used only by SWEEP.
- Step counter:
  - Counts ticks from 0 to H−1, then wraps.
  - A wrap while STATIC with P≠0 toggles phase.
  - A wrap while in SWEEP advances idx R→G→B→R.
- LED drive, where lit_x means the pin is driven 0:
  - STATIC: lit_x = en[x] && (P==0 || phase).
  - SWEEP: lit_x = (idx==x) && en[x]. If en[idx] is 0, that step is dark and the sequence is not skipped.
  - Sweeping = (mode==SWEEP).
- Enable commands received during SWEEP update en immediately and do not exit SWEEP.
- 'S' received while already in SWEEP restarts the sweep at R. 'X' received in STATIC has no effect.

## Timing
- Tick prescaler is free-running from reset. It emits a 1-cycle tick when its count reaches TICK_DIV−1, then wraps to 0. A command never resets it.
- Command latency: a byte accepted at edge N updates internal registers at edge N. LED outputs and Sweeping are registered and change at edge N+1.
- Step/phase/idx update on the edge where tick=1 and the counter equals H−1.
- Simultaneous events: an accepted 'F'-digit or 'S' has priority over a same-cycle wrap. In that case the counter clears and there is no toggle or advance.
- Reset asserted mid-operation forces all registers to their reset values immediately. Reset values are:
  - LED outputs 0 (all lit).
  - Sweeping 0.
  - CmdReady 1.
  - A partially received 'F' is discarded.

## Structure
- Package led_cmd_pkg holds:
  - Command byte constants (CMD_R_ON, CMD_R_OFF, … CMD_STOP).
  - The digit range bounds.
  - Mode and parser state enums.
- Sub-module led_tick_gen (parameter TICK_DIV) contains the prescaler and outputs the tick pulse.
- The parser, step counter and output registers are implemented in the top module.

## Test plan
Sim parameters TICK_DIV=4, STEP_TICKS=2.
- Reset, then idle 20 cycles → R/G/B_LED=0, CmdReady=1, Sweeping=0.
- Send 'g' (103) → G_LED=1 one cycle after accept; CmdReady=0 for exactly one cycle; R_LED/B_LED stay 0.
- Send 'F','3' → in STATIC, all enabled LEDs toggle every 6 ticks (24 cycles). Then send 'F','0' → steady lit.
- Send 'F','Q' then 'r' → P unchanged; 'Q' is not executed; 'r' clears red normally.
- Send 'S' with en=111, P=0 → Sweeping=1; exactly one LED lit, rotating R→G→B every 8 cycles. Then 'X' → STATIC, all lit.
- Assert Reset mid-sweep and between 'F' and its digit → all LEDs lit and Sweeping=0 asynchronously. A subsequent '5' is ignored, with no blink.

Source files
------------

// File: rtl/led_cmd_pkg.sv
// Shared constants and types for the LED command sequencer: command bytes,
// digit bounds, mode/parser/sweep-index encodings.
package led_cmd_pkg;

  localparam logic [7:0] CMD_R_ON  = 8'd82;   // 'R'
  localparam logic [7:0] CMD_R_OFF = 8'd114;  // 'r'
  localparam logic [7:0] CMD_G_ON  = 8'd71;   // 'G'
  localparam logic [7:0] CMD_G_OFF = 8'd103;  // 'g'
  localparam logic [7:0] CMD_B_ON  = 8'd66;   // 'B'
  localparam logic [7:0] CMD_B_OFF = 8'd98;   // 'b'
  localparam logic [7:0] CMD_FREQ  = 8'd70;   // 'F'
  localparam logic [7:0] CMD_SWEEP = 8'd83;   // 'S'
  localparam logic [7:0] CMD_STOP  = 8'd88;   // 'X'

  localparam logic [7:0] DIGIT_LO = 8'd48;    // '0'
  localparam logic [7:0] DIGIT_HI = 8'd57;    // '9'

  // Bit positions inside the enable vector
  localparam int unsigned EN_R = 2;
  localparam int unsigned EN_G = 1;
  localparam int unsigned EN_B = 0;

  typedef enum logic {MODE_STATIC, MODE_SWEEP} mode_e;
  typedef enum logic {P_IDLE, P_ARG} parser_e;
  typedef enum logic [1:0] {IDX_R = 2'd0, IDX_G = 2'd1, IDX_B = 2'd2} idx_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIGIT_LO) && (b <= DIGIT_HI);
  endfunction

  function automatic idx_e next_idx(input idx_e i);
    case (i)
      IDX_R:   return IDX_G;
      IDX_G:   return IDX_B;
      default: return IDX_R;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/led_cmd_sequencer.sv
// Command-byte driven controller for the three active-low LEDs: per-channel
// enables, programmable blink and an R->G->B sweep.
module led_cmd_sequencer
  import led_cmd_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned STEP_TICKS = 100
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Cmd,
  input  logic       CmdValid,
  output logic       CmdReady,
  output logic       R_LED,
  output logic       G_LED,
  output logic       B_LED,
  output logic       Sweeping
);

  localparam int unsigned HMAX = 9 * STEP_TICKS;
  localparam int unsigned SW   = $clog2(HMAX + 1);

  logic          tick;
  logic          ready_q;
  logic [2:0]    en_q, en_d;
  logic [3:0]    period_q, period_d;
  mode_e         mode_q, mode_d;
  parser_e       pstate_q, pstate_d;
  logic          phase_q, phase_d;
  idx_e          idx_q, idx_d;
  logic [SW-1:0] step_q, step_d;
  logic [SW-1:0] half_c;
  logic          wrap_c;
  logic          accept_c;
  logic [2:0]    lit_c;
  logic [2:0]    led_q;
  logic          sweeping_q;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .tick_o (tick)
  );

  assign accept_c = CmdValid && ready_q;
  assign half_c   = (period_q == 4'd0) ? SW'(STEP_TICKS)
                                       : SW'(32'(period_q) * STEP_TICKS);
  assign wrap_c   = tick && (step_q == half_c - SW'(1));

  // Parser, step counter and sequencing state
  always_comb begin
    en_d     = en_q;
    period_d = period_q;
    mode_d   = mode_q;
    pstate_d = pstate_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    step_d   = step_q;

    if (wrap_c) begin
      step_d = '0;
      if (mode_q == MODE_STATIC && period_q != 4'd0) phase_d = ~phase_q;
      if (mode_q == MODE_SWEEP) idx_d = next_idx(idx_q);
    end else if (tick) begin
      step_d = step_q + SW'(1);
    end

    // A restarting command overrides any same-cycle wrap effects
    if (accept_c) begin
      case (pstate_q)
        P_IDLE: begin
          case (Cmd)
            CMD_R_ON:  en_d[EN_R] = 1'b1;
            CMD_R_OFF: en_d[EN_R] = 1'b0;
            CMD_G_ON:  en_d[EN_G] = 1'b1;
            CMD_G_OFF: en_d[EN_G] = 1'b0;
            CMD_B_ON:  en_d[EN_B] = 1'b1;
            CMD_B_OFF: en_d[EN_B] = 1'b0;
            CMD_FREQ:  pstate_d = P_ARG;
            CMD_SWEEP: begin
              mode_d  = MODE_SWEEP;
              idx_d   = IDX_R;
              step_d  = '0;
              phase_d = phase_q;
            end
            CMD_STOP:  mode_d = MODE_STATIC;
            default: ;
          endcase
        end
        default: begin
          pstate_d = P_IDLE;
          if (is_digit(Cmd)) begin
            period_d = Cmd[3:0];
            phase_d  = 1'b1;
            step_d   = '0;
            idx_d    = idx_q;
          end
        end
      endcase
    end
  end

  always_comb begin
    lit_c = '0;
    if (mode_q == MODE_SWEEP) begin
      lit_c[EN_R] = (idx_q == IDX_R) && en_q[EN_R];
      lit_c[EN_G] = (idx_q == IDX_G) && en_q[EN_G];
      lit_c[EN_B] = (idx_q == IDX_B) && en_q[EN_B];
    end else begin
      lit_c = en_q & {3{(period_q == 4'd0) || phase_q}};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ready_q    <= 1'b1;
      en_q       <= 3'b111;
      period_q   <= 4'd0;
      mode_q     <= MODE_STATIC;
      pstate_q   <= P_IDLE;
      phase_q    <= 1'b1;
      idx_q      <= IDX_R;
      step_q     <= '0;
      led_q      <= 3'b000;
      sweeping_q <= 1'b0;
    end else begin
      ready_q    <= ~accept_c;
      en_q       <= en_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      pstate_q   <= pstate_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      led_q      <= ~lit_c;
      sweeping_q <= (mode_q == MODE_SWEEP);
    end
  end

  assign CmdReady = ready_q;
  assign R_LED    = led_q[EN_R];
  assign G_LED    = led_q[EN_G];
  assign B_LED    = led_q[EN_B];
  assign Sweeping = sweeping_q;

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Randomized bench for led_cmd_sequencer against a cycle-level behavioural
// model of the command/blink/sweep rules.
module tb_led_cmd_sequencer;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned STEP_TICKS = 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Cmd = 8'd0;
  logic       CmdValid = 1'b0;
  logic       CmdReady, R_LED, G_LED, B_LED, Sweeping;

  int total = 0;
  int bad   = 0;

  // Model state: channel index 0=R, 1=G, 2=B
  bit m_en[3];
  int m_p;
  bit m_sweep;
  bit m_arg;
  bit m_phase;
  int m_idx;
  int m_steps;
  int m_edges;
  bit m_ready;
  bit e_led[3];
  bit e_sw;

  logic [7:0] pool [0:13] = '{8'd82, 8'd114, 8'd71, 8'd103, 8'd66, 8'd98,
                              8'd70, 8'd83, 8'd88, 8'd48, 8'd51, 8'd53,
                              8'd57, 8'd81};

  led_cmd_sequencer #(.TICK_DIV(TICK_DIV), .STEP_TICKS(STEP_TICKS)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Cmd      (Cmd),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .R_LED    (R_LED),
    .G_LED    (G_LED),
    .B_LED    (B_LED),
    .Sweeping (Sweeping)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int x = 0; x < 3; x++) m_en[x] = 1'b1;
    m_p = 0; m_sweep = 0; m_arg = 0; m_phase = 1; m_idx = 0;
    m_steps = 0; m_edges = 0; m_ready = 1;
  endtask

  // Advance the model across one rising edge with the given inputs
  task automatic model_edge(input logic v, input logic [7:0] b);
    bit tick, acc, wrap, restart, old_sweep, lit;
    int old_p, h;
    for (int x = 0; x < 3; x++) begin
      lit = m_sweep ? (m_idx == x && m_en[x]) : (m_en[x] && (m_p == 0 || m_phase));
      e_led[x] = !lit;
    end
    e_sw = m_sweep;
    tick = (m_edges % TICK_DIV) == TICK_DIV - 1;
    m_edges++;
    acc = v && m_ready;
    m_ready = !acc;
    old_sweep = m_sweep;
    old_p = m_p;
    h = (m_p == 0) ? STEP_TICKS : m_p * STEP_TICKS;
    wrap = tick && (m_steps == h - 1);
    restart = 0;
    if (acc) begin
      if (m_arg) begin
        m_arg = 0;
        if (b >= 48 && b <= 57) begin
          m_p = int'(b) - 48; m_phase = 1; restart = 1;
        end
      end else begin
        case (b)
          8'd82:  m_en[0] = 1;
          8'd114: m_en[0] = 0;
          8'd71:  m_en[1] = 1;
          8'd103: m_en[1] = 0;
          8'd66:  m_en[2] = 1;
          8'd98:  m_en[2] = 0;
          8'd70:  m_arg = 1;
          8'd83:  begin m_sweep = 1; m_idx = 0; restart = 1; end
          8'd88:  m_sweep = 0;
          default: ;
        endcase
      end
    end
    if (restart) m_steps = 0;
    else if (wrap) begin
      m_steps = 0;
      if (!old_sweep && old_p != 0) m_phase = !m_phase;
      if (old_sweep) m_idx = (m_idx + 1) % 3;
    end else if (tick) m_steps++;
  endtask

  // Called just after an edge; drives inputs, takes one edge, checks outputs
  task automatic cycle(input logic v, input logic [7:0] b);
    CmdValid = v;
    Cmd = b;
    @(posedge Clock);
    model_edge(v, b);
    #1;
    check_eq("r_led", 32'(R_LED), 32'(e_led[0]));
    check_eq("g_led", 32'(G_LED), 32'(e_led[1]));
    check_eq("b_led", 32'(B_LED), 32'(e_led[2]));
    check_eq("sweeping", 32'(Sweeping), 32'(e_sw));
    check_eq("cmd_ready", 32'(CmdReady), 32'(m_ready));
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
    cycle(1'b0, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs must go to reset values before any edge
  task automatic do_reset();
    #2 Reset = 1'b1;
    CmdValid = 1'b0;
    #1;
    check_eq("rst_r_led", 32'(R_LED), 32'd0);
    check_eq("rst_g_led", 32'(G_LED), 32'd0);
    check_eq("rst_b_led", 32'(B_LED), 32'd0);
    check_eq("rst_sweeping", 32'(Sweeping), 32'd0);
    check_eq("rst_cmd_ready", 32'(CmdReady), 32'd1);
    @(posedge Clock);
    @(posedge Clock);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic       v;
    logic [7:0] b;
    model_reset();
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check_eq("init_r_led", 32'(R_LED), 32'd0);
    check_eq("init_ready", 32'(CmdReady), 32'd1);
    Reset = 1'b0;

    idle(20);
    send(8'd103);                       // 'g'
    idle(5);
    send(8'd70); send(8'd51);           // 'F','3'
    idle(60);
    send(8'd70); send(8'd48);           // 'F','0'
    idle(10);
    send(8'd70); send(8'd81); send(8'd114);  // 'F','Q','r'
    idle(20);
    send(8'd82); send(8'd71);           // restore en=111
    send(8'd83);                        // 'S'
    idle(30);
    send(8'd88);                        // 'X'
    idle(10);
    send(8'd88);
    send(8'd83);
    idle(12);
    do_reset();                         // mid-sweep
    idle(5);
    send(8'd70);
    do_reset();                         // between 'F' and digit
    send(8'd53);                        // '5' must be ignored
    idle(40);

    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 7) == 0);
      b = pool[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      if ($urandom_range(0, 3) == 0 && v) begin
        cycle(1'b1, b);
        cycle(1'b1, pool[$urandom_range(0, 13)]);  // valid while not ready
      end else begin
        cycle(v, b);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
